pkt_sched: RTL
==============

# pkt_sched

Packet write scheduler for the capture path. It queues packet descriptors from the capture front end and allocates space for each one in a host-memory ring buffer. It sequences `wr_ctrl` one packet at a time and reports ring progress to the host. It sits between the capture descriptor source, the host CSR block and `wr_ctrl`.

## Interface
- `DESC_DEPTH`, 8: descriptor queue depth; power of two, at least 2.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-low.
- `enable` in 1: scheduler enable (CSR).
- `ring_base` in 32: ring byte base address. Static while `enable`=1.
- `ring_size` in 32: ring size in bytes. Multiple of 4, at least 8. Static while `enable`=1.
- `rd_ptr` in 32: host consume offset. Multiple of 4, less than `ring_size`.
- `desc_valid` in 1: descriptor offered.
- `desc_ready` out 1: queue not full.
- `desc_begin` in 32: packet start pointer.
- `desc_end` in 32: packet end pointer.
- `wr_ctrl` out 1: start pulse to `wr_ctrl`.
- `control` out 32: `{seq[15:0], 16'h0001}`.
- `pkt_begin` out 32: forwarded descriptor begin.
- `pkt_end` out 32: forwarded descriptor end.
- `write_address` out 32: `ring_base` plus the placement offset.
- `wr_ctrl_rdy` in 1: completion pulse from `wr_ctrl`.
- `wr_ptr` out 32: produce offset.
- `wrap_mark` out 32: end of valid data before the last wrap.
- `pkt_count` out 16: committed packets (wraps).
- `drop_count` out 16: dropped packets (saturates at 0xFFFF).
- `busy` out 1: state is not IDLE.
- `irq` out 1: one-cycle commit pulse.

## Operation
- A descriptor is pushed when `desc_valid && desc_ready`.
- FSM states: IDLE, CHECK, START, WAIT, COMMIT.
- IDLE → CHECK when `enable`=1 and the queue is not empty. The head entry is popped into working registers.
- CHECK computes `len = (desc_end - desc_begin + 3) & ~3`, modulo 2^32.
- A descriptor is bad when `len`==0, `len` > `ring_size` - 4, or `len` > 0xFFFC. A bad descriptor is dropped: `drop_count`++, CHECK → IDLE.
- Placement, no-wrap case: if `wr_ptr + len <= ring_size`, then `place = wr_ptr`. It fits when `len <= free`:
  - `free = rd_ptr - wr_ptr - 4` when `rd_ptr > wr_ptr`;
  - `free = ring_size - wr_ptr + rd_ptr - 4` otherwise.
- Placement, wrap case: otherwise `place = 0`. It fits only when `rd_ptr <= wr_ptr` and `len + 4 <= rd_ptr`.
- CHECK → START on fit. On no fit, see Configuration.
- START asserts `wr_ctrl`=1 for one cycle, then → WAIT. `pkt_begin`, `pkt_end`, `write_address` and `control` are driven from START until COMMIT and held stable.
- WAIT → COMMIT on `wr_ctrl_rdy`. There is no timeout.
- COMMIT:
  - If wrapped, `wrap_mark` ← old `wr_ptr`.
  - `wr_ptr` ← `place + len`, or 0 when that equals `ring_size`.
  - `pkt_count`++, `seq`++, `irq`=1. Then → IDLE.
- `enable` low: no new pops. An in-flight packet still completes.
- On an `enable` 0→1 edge, `wr_ptr` and `wrap_mark` clear to 0.

## Timing
- Reset values: all outputs 0, except `desc_ready`=1. The queue empties, FSM → IDLE, `seq`=0.
- Reset mid-packet abandons the packet. `wr_ctrl` shares the same reset.
- Push and pop in the same cycle are allowed. When the queue is full, `desc_ready` drops in the cycle after the fill.
- Latency: push accepted at cycle N → head visible N+1 → pop/IDLE N+1 → CHECK N+2 → `wr_ctrl` high at N+3.
- `wr_ctrl_rdy` at cycle M → `wr_ptr`, `pkt_count` and `irq` update at M+1. IDLE at M+2.
- `rd_ptr` is sampled only in CHECK. Host updates at any other time take effect on the next CHECK.

## Configuration
- `PKT_SCHED_BACKPRESSURE_EN` defined: on no fit, the scheduler stays in CHECK, re-evaluates every cycle, and never drops for space. Bad descriptors are still dropped.
- Not defined: on no fit, `drop_count`++ and CHECK → IDLE.

## Structure
- Package `pkt_sched_pkg` holds:
  - the state enum typedef;
  - the descriptor struct `{begin, end}`;
  - constants `MAX_LEN`=0xFFFC, `RING_GAP`=4, `CTRL_START`=16'h0001.
- Sub-module `pkt_desc_fifo`: synchronous descriptor FIFO, depth `DESC_DEPTH`, with full/empty flags.

## Test plan
- Basic write: `ring_base`=0x1000_0000, `ring_size`=0x100, `rd_ptr`=0; push begin=0x40, end=0x80.
  - `wr_ctrl` pulses with `write_address`=0x1000_0000.
  - After `wr_ctrl_rdy`: `wr_ptr`=0x40, `pkt_count`=1, one `irq` pulse.
- Wrap: `wr_ptr`=0xE0, `rd_ptr`=0x80, len=0x40.
  - `write_address`=0x1000_0000; after commit `wrap_mark`=0xE0, `wr_ptr`=0x40.
- Full ring: `wr_ptr`=0x7C, `rd_ptr`=0x80, len=0x10.
  - Macro off: `drop_count`=1 and no `wr_ctrl` pulse.
  - Macro on: the scheduler stalls in CHECK; setting `rd_ptr`=0xC0 starts the transfer.
- Bad descriptors: begin=end=0x40, then len 0x1_0000.
  - Both dropped, `drop_count`=2, no `wr_ctrl`.
- Queue: push 9 descriptors back-to-back with `enable`=0.
  - `desc_ready` low after 8.
  - Set `enable`=1: 8 ordered transfers with `seq` 0–7.
- Reset in WAIT: all outputs return to reset values and the queue is empty.

Source files
------------

// File: rtl/pkt_sched_pkg.sv
// Shared types and constants for the capture-path packet write scheduler.
package pkt_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_START,
        S_WAIT,
        S_COMMIT
    } state_e;

    typedef struct packed {
        logic [31:0] begin_ptr;
        logic [31:0] end_ptr;
    } desc_t;

    localparam logic [31:0] MAX_LEN    = 32'h0000_FFFC;
    localparam logic [31:0] RING_GAP   = 32'd4;
    localparam logic [15:0] CTRL_START = 16'h0001;

endpackage

// File: rtl/pkt_desc_fifo.sv
// Synchronous descriptor FIFO; head entry is visible combinationally on rdata_o.
module pkt_desc_fifo
    import pkt_sched_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  push_i,
    input  desc_t wdata_i,
    input  logic  pop_i,
    output desc_t rdata_o,
    output logic  full_o,
    output logic  empty_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    desc_t         mem_q [DEPTH];
    logic [AW:0]   wptr_q;
    logic [AW:0]   rptr_q;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wptr_q <= wptr_q + PTR_ONE;
            end
            if (pop_i && !empty_o) begin
                rptr_q <= rptr_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

endmodule

// File: rtl/pkt_sched.sv
// Packet write scheduler: queues descriptors, places them in the host ring and sequences wr_ctrl.
// Defining PKT_SCHED_BACKPRESSURE_EN makes CHECK stall on a full ring instead of dropping.
module pkt_sched
    import pkt_sched_pkg::*;
#(
    parameter int DESC_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] ring_base,
    input  logic [31:0] ring_size,
    input  logic [31:0] rd_ptr,
    input  logic        desc_valid,
    output logic        desc_ready,
    input  logic [31:0] desc_begin,
    input  logic [31:0] desc_end,
    output logic        wr_ctrl,
    output logic [31:0] control,
    output logic [31:0] pkt_begin,
    output logic [31:0] pkt_end,
    output logic [31:0] write_address,
    input  logic        wr_ctrl_rdy,
    output logic [31:0] wr_ptr,
    output logic [31:0] wrap_mark,
    output logic [15:0] pkt_count,
    output logic [15:0] drop_count,
    output logic        busy,
    output logic        irq
);
    state_e      state_q;
    desc_t       desc_q, fifo_head;
    logic        fifo_full, fifo_empty, pop;
    logic        wr_ctrl_q, irq_q, enable_q, wrapped_q;
    logic [15:0] seq_q, pkt_count_q, drop_count_q;
    logic [31:0] wr_ptr_q, wrap_mark_q, place_q, len_q;
    logic [31:0] control_q, pkt_begin_q, pkt_end_q, write_address_q;
    logic [31:0] len_c, free_c, wr_ptr_d;
    logic [32:0] sum_c;
    logic        bad_c, nowrap_c, fit_c;

    assign pop = (state_q == S_IDLE) && enable && !fifo_empty;

    pkt_desc_fifo #(.DEPTH(DESC_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (desc_valid),
        .wdata_i ('{begin_ptr: desc_begin, end_ptr: desc_end}),
        .pop_i   (pop),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Length rounding and ring placement; only meaningful while in CHECK.
    always_comb begin
        len_c    = (desc_q.end_ptr - desc_q.begin_ptr + 32'd3) & ~32'd3;
        bad_c    = (len_c == 32'd0) || (len_c > ring_size - RING_GAP) || (len_c > MAX_LEN);
        sum_c    = {1'b0, wr_ptr_q} + {1'b0, len_c};
        nowrap_c = (sum_c <= {1'b0, ring_size});
        free_c   = (rd_ptr > wr_ptr_q) ? (rd_ptr - wr_ptr_q - RING_GAP)
                                       : (ring_size - wr_ptr_q + rd_ptr - RING_GAP);
        fit_c    = nowrap_c ? (len_c <= free_c)
                            : ((rd_ptr <= wr_ptr_q) && (({1'b0, len_c} + {1'b0, RING_GAP}) <= {1'b0, rd_ptr}));
        wr_ptr_d = place_q + len_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= S_IDLE;
            desc_q          <= '0;
            wr_ctrl_q       <= 1'b0;
            irq_q           <= 1'b0;
            enable_q        <= 1'b0;
            wrapped_q       <= 1'b0;
            seq_q           <= '0;
            pkt_count_q     <= '0;
            drop_count_q    <= '0;
            wr_ptr_q        <= '0;
            wrap_mark_q     <= '0;
            place_q         <= '0;
            len_q           <= '0;
            control_q       <= '0;
            pkt_begin_q     <= '0;
            pkt_end_q       <= '0;
            write_address_q <= '0;
        end else begin
            wr_ctrl_q <= 1'b0;
            irq_q     <= 1'b0;
            enable_q  <= enable;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        desc_q  <= fifo_head;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (bad_c) begin
                        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
                        state_q <= S_IDLE;
                    end else if (fit_c) begin
                        place_q         <= nowrap_c ? wr_ptr_q : 32'd0;
                        wrapped_q       <= !nowrap_c;
                        len_q           <= len_c;
                        pkt_begin_q     <= desc_q.begin_ptr;
                        pkt_end_q       <= desc_q.end_ptr;
                        write_address_q <= ring_base + (nowrap_c ? wr_ptr_q : 32'd0);
                        control_q       <= {seq_q, CTRL_START};
                        wr_ctrl_q       <= 1'b1;
                        state_q         <= S_START;
                    end else begin
`ifdef PKT_SCHED_BACKPRESSURE_EN
                        state_q <= S_CHECK;
`else
                        if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
                        state_q <= S_IDLE;
`endif
                    end
                end
                S_START: state_q <= S_WAIT;
                S_WAIT: begin
                    if (wr_ctrl_rdy) begin
                        if (wrapped_q) wrap_mark_q <= wr_ptr_q;
                        wr_ptr_q    <= (wr_ptr_d == ring_size) ? 32'd0 : wr_ptr_d;
                        pkt_count_q <= pkt_count_q + 16'd1;
                        seq_q       <= seq_q + 16'd1;
                        irq_q       <= 1'b1;
                        state_q     <= S_COMMIT;
                    end
                end
                S_COMMIT: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
            // A fresh enable restarts the ring from offset zero.
            if (enable && !enable_q) begin
                wr_ptr_q    <= '0;
                wrap_mark_q <= '0;
            end
        end
    end

    assign desc_ready    = !fifo_full;
    assign wr_ctrl       = wr_ctrl_q;
    assign control       = control_q;
    assign pkt_begin     = pkt_begin_q;
    assign pkt_end       = pkt_end_q;
    assign write_address = write_address_q;
    assign wr_ptr        = wr_ptr_q;
    assign wrap_mark     = wrap_mark_q;
    assign pkt_count     = pkt_count_q;
    assign drop_count    = drop_count_q;
    assign busy          = (state_q != S_IDLE);
    assign irq           = irq_q;

endmodule
